exa_traffic_producer_with_vcs: RTL

EXA_TRAFFIC_PRODUCER_WITH_VCS -- requirements
Module: exa_traffic_producer_with_vcs

---
 rtl/exa_traffic_producer_with_vcs_if.sv | 31 +++
 rtl/exa_traffic_producer_with_vcs.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/exa_traffic_producer_with_vcs_if.sv
// Exanet link: three flit classes, each with its own valid/ready pair,
// sharing one 128-bit data bus.
interface exanet;
  logic         header_valid;
  logic         header_ready;
  logic         payload_valid;
  logic         payload_ready;
  logic         footer_valid;
  logic         footer_ready;
  logic [127:0] data;

  modport master (
    output header_valid,
    output payload_valid,
    output footer_valid,
    output data,
    input  header_ready,
    input  payload_ready,
    input  footer_ready
  );

  modport slave (
    input  header_valid,
    input  payload_valid,
    input  footer_valid,
    input  data,
    output header_ready,
    output payload_ready,
    output footer_ready
  );
endinterface

// File: rtl/exa_traffic_producer_with_vcs.sv
// Round-robin packet generator over VC_NUM*PRIO_NUM virtual channels,
// emitting header/payload/footer flits with a self-describing pattern.
module exa_traffic_producer_with_vcs #(
  parameter  int PRIO_NUM      = 2,
  parameter  int VC_NUM        = 2,
  parameter  int PAYLOAD_FLITS = 16,
  parameter  int PKTS_PER_VC   = 3,
  localparam int N             = VC_NUM * PRIO_NUM,
  localparam int W             = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] i_vc_enable,
  exanet.master        exa,
  output logic [W-1:0] o_vc,
  output logic         o_pkt_sent,
  output logic         o_done
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    FOOTER
  } state_t;

  state_t       state;
  logic         armed;
  logic [7:0]   idx;
  logic [W-1:0] rr_ptr;
  logic [15:0]  sent_cnt [N];
  logic [23:0]  seq      [N];

  logic [15:0]  cnt_nx   [N];
  logic [N-1:0] elig;
  logic         any_elig;
  logic [W-1:0] gnt;
  logic [W-1:0] gnt_nxt;
  logic [23:0]  gnt_seq;
  logic         fire_f;
  logic         start;
  int           pos;

  function automatic logic [127:0] flit(
    input logic [W-1:0] vc,
    input logic [23:0]  s,
    input logic [7:0]   f
  );
    logic [31:0] hi;
    hi   = {s, f};
    flit = {8'(vc), hi, 56'd0, ~hi};
  endfunction

  assign fire_f     = exa.footer_valid & exa.footer_ready;
  assign o_pkt_sent = fire_f;

  // Eligibility sees the count as it will be after a footer in this cycle,
  // so arbitration at the footer does not regrant an exhausted channel.
  always_comb begin
    elig = '0;
    for (int c = 0; c < N; c++) begin
      cnt_nx[c] = sent_cnt[c]
                + {15'd0, (fire_f && o_vc == W'(c))};
      elig[c]   = i_vc_enable[c]
                && (cnt_nx[c] < 16'(PKTS_PER_VC));
    end
  end

  always_comb begin
    any_elig = 1'b0;
    gnt      = '0;
    pos      = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(rr_ptr) + i) % N;
      if (!any_elig && elig[pos]) begin
        any_elig = 1'b1;
        gnt      = W'(pos);
      end
    end
  end

  always_comb begin
    gnt_nxt = (gnt == W'(N - 1)) ? '0 : gnt + W'(1);
    gnt_seq = seq[gnt]
            + {23'd0, (fire_f && gnt == o_vc)};
  end

  always_comb begin
    o_done = 1'b1;
    for (int c = 0; c < N; c++)
      if (sent_cnt[c] != 16'(PKTS_PER_VC))
        o_done = 1'b0;
  end

  assign start = any_elig
               && ((state == IDLE && armed) || fire_f);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      armed             <= 1'b0;
      idx               <= '0;
      rr_ptr            <= '0;
      o_vc              <= '0;
      exa.header_valid  <= 1'b0;
      exa.payload_valid <= 1'b0;
      exa.footer_valid  <= 1'b0;
      exa.data          <= '0;
      for (int c = 0; c < N; c++) begin
        sent_cnt[c] <= '0;
        seq[c]      <= '0;
      end
    end else begin
      armed <= 1'b1;
      if (fire_f) begin
        sent_cnt[o_vc] <= sent_cnt[o_vc] + 16'd1;
        seq[o_vc]      <= seq[o_vc] + 24'd1;
      end
      unique case (state)
        IDLE: ;
        HEADER: begin
          if (exa.header_ready) begin
            exa.header_valid  <= 1'b0;
            exa.payload_valid <= 1'b1;
            idx               <= 8'd1;
            exa.data          <= flit(o_vc, seq[o_vc], 8'd1);
            state             <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (exa.payload_ready) begin
            if (idx == 8'(PAYLOAD_FLITS)) begin
              exa.payload_valid <= 1'b0;
              exa.footer_valid  <= 1'b1;
              idx      <= 8'(PAYLOAD_FLITS + 1);
              exa.data <= flit(o_vc, seq[o_vc],
                               8'(PAYLOAD_FLITS + 1));
              state    <= FOOTER;
            end else begin
              idx      <= idx + 8'd1;
              exa.data <= flit(o_vc, seq[o_vc],
                               idx + 8'd1);
            end
          end
        end
        FOOTER: begin
          if (exa.footer_ready) begin
            exa.footer_valid <= 1'b0;
            state            <= IDLE;
          end
        end
      endcase
      // Grant overrides the footer's fall-back to IDLE: no bubble.
      if (start) begin
        state            <= HEADER;
        exa.header_valid <= 1'b1;
        o_vc             <= gnt;
        rr_ptr           <= gnt_nxt;
        idx              <= '0;
        exa.data         <= flit(gnt, gnt_seq, 8'd0);
      end
    end
  end

endmodule
